// File: rtl/onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter_if
//
// Purpose:
//   Bundles every bus signal around the shared on-chip RAM arbiter: the
//   per-core Avalon-MM data master side (flattened vectors, master k in
//   slice k) and the single-port RAM slave side.
//
// Modports:
//   master : the cores and the RAM, i.e. everything around the arbiter.
//            Drives requests and mem_readdata, observes the arbiter outputs.
//   slave  : the arbiter itself.
//
// Signals:
//   m_req          per-master request (read or write)
//   m_write        per-master 1=write, 0=read
//   m_address      master k at [k*ADDR_W +: ADDR_W]
//   m_byteenable   master k at [k*BE_W +: BE_W]
//   m_writedata    master k at [k*DATA_W +: DATA_W]
//   m_lock         per-master hold-grant request
//   m_waitrequest  1 = request not accepted this cycle
//   m_readdata     shared read-return bus
//   m_readdatavalid one-hot owner of m_readdata
//   mem_*          single-port RAM interface, 1-cycle read latency
// ---------------------------------------------------------------------------
interface onchip_mem_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4
);
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS*BE_W-1:0]   m_byteenable;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_lock;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [DATA_W-1:0]             m_readdata;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;

    logic                          mem_chipselect;
    logic                          mem_write;
    logic [ADDR_W-1:0]             mem_address;
    logic [BE_W-1:0]               mem_byteenable;
    logic [DATA_W-1:0]             mem_writedata;
    logic                          mem_clken;
    logic [DATA_W-1:0]             mem_readdata;

    modport master (
        output m_req, m_write, m_address, m_byteenable, m_writedata, m_lock,
        output mem_readdata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  mem_chipselect, mem_write, mem_address, mem_byteenable,
        input  mem_writedata, mem_clken
    );

    modport slave (
        input  m_req, m_write, m_address, m_byteenable, m_writedata, m_lock,
        input  mem_readdata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output mem_chipselect, mem_write, mem_address, mem_byteenable,
        output mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Purpose:
//   Round-robin arbiter sharing one single-port on-chip RAM (byte-enabled,
//   1-cycle read latency) among NUM_MASTERS cores. One transfer is accepted
//   per cycle; read data comes back one cycle later on a shared bus tagged
//   by a one-hot readdatavalid.
//
// Ports:
//   clk      system clock
//   reset_n  synchronous, active-low reset
//   bus      onchip_mem_arbiter_if.slave: per-master request/response
//            vectors plus the RAM slave port (see the interface file)
//
// Optional feature:
//   Define ONCHIP_ARB_LOCK_EN to let a master holding m_lock keep the grant
//   for up to LOCK_MAX consecutive transfers. Without it m_lock is ignored
//   and arbitration is pure round-robin.
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4,
    parameter int LOCK_MAX    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   bus
);

    localparam int              PTR_W    = $clog2(NUM_MASTERS);
    localparam logic [PTR_W:0]  NUM_M_W  = (PTR_W+1)'(NUM_MASTERS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS-1);

    // Successor of a master index in the circular search order.
    function automatic logic [PTR_W-1:0] nextIdx(input logic [PTR_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
    logic             rdPending_q, rdPending_d;
    logic [PTR_W-1:0] rdOwner_q, rdOwner_d;

    logic             grantValid;
    logic [PTR_W-1:0] grantIdx;

    logic             lockActive;
    logic [PTR_W-1:0] lockOwner;
    logic             lockExit;

`ifdef ONCHIP_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX+1);

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arbState_e;

    arbState_e        state_q, state_d;
    logic [PTR_W-1:0] lockOwner_q, lockOwner_d;
    logic [CNT_W-1:0] lockCnt_q, lockCnt_d;

    // Lock state register. Reset always drops back to plain round-robin.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            lockOwner_q <= '0;
            lockCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lockOwner_q <= lockOwner_d;
            lockCnt_q   <= lockCnt_d;
        end
    end

    // Lock next-state logic. A locked master keeps the grant while it keeps
    // requesting with m_lock high, up to LOCK_MAX transfers in a row. In
    // LOCKED, grantValid can only be for the owner, so a missing grant means
    // the owner stopped requesting. lockExit tells the pointer logic to
    // resume the rotation just after the owner.
    always_comb begin
        state_d     = state_q;
        lockOwner_d = lockOwner_q;
        lockCnt_d   = lockCnt_q;
        lockExit    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grantValid && bus.m_lock[grantIdx] && (LOCK_MAX > 1)) begin
                    state_d     = ARB_LOCKED;
                    lockOwner_d = grantIdx;
                    lockCnt_d   = CNT_W'(1);
                end
            end
            ARB_LOCKED: begin
                if (!grantValid || !bus.m_lock[lockOwner_q]) begin
                    state_d   = ARB_IDLE;
                    lockCnt_d = '0;
                    lockExit  = 1'b1;
                end else begin
                    lockCnt_d = lockCnt_q + 1'b1;
                    if (lockCnt_d == CNT_W'(LOCK_MAX)) begin
                        state_d   = ARB_IDLE;
                        lockCnt_d = '0;
                        lockExit  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign lockActive = (state_q == ARB_LOCKED);
    assign lockOwner  = lockOwner_q;
`else
    logic unusedLock;
    localparam int unusedLockMax = LOCK_MAX;

    assign unusedLock = ^bus.m_lock;
    assign lockActive = 1'b0;
    assign lockOwner  = '0;
    assign lockExit   = 1'b0;
`endif

    // Grant selection. The loop walks the circular order backwards from the
    // farthest offset to offset 0, so the last hit (the one that sticks) is
    // the first requester at or after rrPtr_q. The wider sum keeps the
    // modulo wrap exact for non-power-of-two master counts. While locked
    // only the lock owner is eligible. Nothing is granted during reset.
    always_comb begin
        logic [PTR_W:0] sum;
        grantValid = 1'b0;
        grantIdx   = '0;
        sum        = '0;
        if (reset_n) begin
            if (lockActive) begin
                if (bus.m_req[lockOwner]) begin
                    grantValid = 1'b1;
                    grantIdx   = lockOwner;
                end
            end else begin
                for (int i = NUM_MASTERS-1; i >= 0; i--) begin
                    sum = {1'b0, rrPtr_q} + (PTR_W+1)'(i);
                    if (sum >= NUM_M_W) begin
                        sum = sum - NUM_M_W;
                    end
                    if (bus.m_req[sum[PTR_W-1:0]]) begin
                        grantValid = 1'b1;
                        grantIdx   = sum[PTR_W-1:0];
                    end
                end
            end
        end
    end

    // Request path mux. The granted master's command goes straight to the
    // RAM in the same cycle; everyone else sees waitrequest and holds.
    // waitrequest depends only on m_req and registered state.
    always_comb begin
        bus.mem_chipselect = grantValid;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        bus.mem_clken      = 1'b1;
        bus.m_waitrequest  = '1;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grantValid && (grantIdx == PTR_W'(k))) begin
                bus.mem_write        = bus.m_write[k];
                bus.mem_address      = bus.m_address[k*ADDR_W +: ADDR_W];
                bus.mem_byteenable   = bus.m_byteenable[k*BE_W +: BE_W];
                bus.mem_writedata    = bus.m_writedata[k*DATA_W +: DATA_W];
                bus.m_waitrequest[k] = 1'b0;
            end
        end
    end

    // Read return path. The RAM data is simply forwarded; the one-hot valid
    // names the master whose read was accepted on the previous cycle. A
    // read caught by reset never produces a valid.
    always_comb begin
        bus.m_readdata      = bus.mem_readdata;
        bus.m_readdatavalid = '0;
        if (reset_n && rdPending_q) begin
            bus.m_readdatavalid[rdOwner_q] = 1'b1;
        end
    end

    // Next-state for the rotation pointer and the one-deep read tracker.
    // A read is outstanding for exactly one cycle, so a new read can be
    // accepted every cycle at full throughput. Leaving a lock restarts the
    // rotation just after the lock owner.
    always_comb begin
        rrPtr_d     = rrPtr_q;
        rdPending_d = 1'b0;
        rdOwner_d   = rdOwner_q;
        if (grantValid) begin
            rrPtr_d = nextIdx(grantIdx);
            if (!bus.m_write[grantIdx]) begin
                rdPending_d = 1'b1;
                rdOwner_d   = grantIdx;
            end
        end
        if (lockExit) begin
            rrPtr_d = nextIdx(lockOwner);
        end
    end

    // Arbiter state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rrPtr_q     <= '0;
            rdPending_q <= 1'b0;
            rdOwner_q   <= '0;
        end else begin
            rrPtr_q     <= rrPtr_d;
            rdPending_q <= rdPending_d;
            rdOwner_q   <= rdOwner_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//
// Self-checking bench for onchip_mem_arbiter with 4 masters. A behavioural
// RAM sits on the mem_* port. A cycle-level reference model (rotation
// pointer, shadow memory, pending read) is compared against the DUT on
// every negative edge, and directed scenarios pin literal expectations.
// Honours ONCHIP_ARB_LOCK_EN for the lock scenario.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

    localparam int N        = 4;
    localparam int AW       = 13;
    localparam int DW       = 32;
    localparam int BW       = 4;
    localparam int LOCK_MAX = 16;

    logic clk = 1'b0;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

    onchip_mem_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Driven master inputs (changed only just after a rising edge)
    logic [N-1:0]  mReq, mWrite, mLock;
    logic [AW-1:0] mAddr [N];
    logic [BW-1:0] mBe   [N];
    logic [DW-1:0] mData [N];

    // Staged values, copied onto the bus by applyStimulus
    logic          sRst;
    logic [N-1:0]  sReq, sWrite, sLock;
    logic [AW-1:0] sAddr [N];
    logic [BW-1:0] sBe   [N];
    logic [DW-1:0] sData [N];

    // Pack the per-master inputs into the flattened interface vectors
    always_comb begin
        bus.m_req        = mReq;
        bus.m_write      = mWrite;
        bus.m_lock       = mLock;
        bus.m_address    = '0;
        bus.m_byteenable = '0;
        bus.m_writedata  = '0;
        for (int k = 0; k < N; k++) begin
            bus.m_address[k*AW +: AW]    = mAddr[k];
            bus.m_byteenable[k*BW +: BW] = mBe[k];
            bus.m_writedata[k*DW +: DW]  = mData[k];
        end
    end

    // Behavioural single-port RAM, byte-enabled, 1-cycle read latency
    logic [DW-1:0] ram [8192];
    logic [DW-1:0] ramQ;

    assign bus.mem_readdata = ramQ;

    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.mem_byteenable[b]) begin
                        ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
                    end
                end
            end else begin
                ramQ <= ram[bus.mem_address];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model state
    int            mPtr;
    bit            mPend;
    int            mPendOwner;
    logic [DW-1:0] mPendData;
    bit            mLocked;
    int            mLockOwner;
    int            mLockCnt;
    logic [DW-1:0] shadow [8192];

    // Model compare: inputs are stable from just after the rising edge, so
    // at the falling edge the model decides who must be granted from the
    // rotation rule, checks every DUT output, then advances its own state
    // to what the next rising edge will commit.
    always @(negedge clk) begin : modelCompare
        int            g;
        logic [N-1:0]  expWait;
        logic [N-1:0]  expRdv;
        if (!reset_n) begin
            checkOutput("model_rst_wait", 32'(bus.m_waitrequest), 32'hF);
            checkOutput("model_rst_cs", 32'(bus.mem_chipselect), 32'h0);
            checkOutput("model_rst_rdv", 32'(bus.m_readdatavalid), 32'h0);
            checkOutput("model_rst_clken", 32'(bus.mem_clken), 32'h1);
            mPtr     = 0;
            mPend    = 1'b0;
            mLocked  = 1'b0;
            mLockCnt = 0;
        end else begin
            g = -1;
            if (mLocked) begin
                if (mReq[mLockOwner]) g = mLockOwner;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && mReq[(mPtr + i) % N]) g = (mPtr + i) % N;
                end
            end
            expWait = '1;
            if (g >= 0) expWait[g] = 1'b0;
            expRdv = '0;
            if (mPend) expRdv[mPendOwner] = 1'b1;

            checkOutput("model_wait", 32'(bus.m_waitrequest), 32'(expWait));
            checkOutput("model_cs", 32'(bus.mem_chipselect), 32'(g >= 0));
            checkOutput("model_clken", 32'(bus.mem_clken), 32'h1);
            checkOutput("model_rdv", 32'(bus.m_readdatavalid), 32'(expRdv));
            if (mPend) checkOutput("model_rdata", bus.m_readdata, mPendData);
            if (g >= 0) begin
                checkOutput("model_mem_write", 32'(bus.mem_write), 32'(mWrite[g]));
                checkOutput("model_mem_addr", 32'(bus.mem_address), 32'(mAddr[g]));
                checkOutput("model_mem_be", 32'(bus.mem_byteenable), 32'(mBe[g]));
                if (mWrite[g]) checkOutput("model_mem_wdata", bus.mem_writedata, mData[g]);
            end

            mPend = 1'b0;
            if (g >= 0) begin
                if (mWrite[g]) begin
                    for (int b = 0; b < BW; b++) begin
                        if (mBe[g][b]) shadow[mAddr[g]][b*8 +: 8] = mData[g][b*8 +: 8];
                    end
                end else begin
                    mPend      = 1'b1;
                    mPendOwner = g;
                    mPendData  = shadow[mAddr[g]];
                end
                mPtr = (g + 1) % N;
            end
`ifdef ONCHIP_ARB_LOCK_EN
            if (mLocked) begin
                if (g < 0 || !mLock[mLockOwner]) begin
                    mLocked = 1'b0;
                    mPtr    = (mLockOwner + 1) % N;
                end else begin
                    mLockCnt++;
                    if (mLockCnt == LOCK_MAX) begin
                        mLocked = 1'b0;
                        mPtr    = (mLockOwner + 1) % N;
                    end
                end
            end else if (g >= 0 && mLock[g]) begin
                mLocked    = 1'b1;
                mLockOwner = g;
                mLockCnt   = 1;
            end
`endif
        end
    end

    // Stimulus helpers
    task automatic stage(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d, input logic lk);
        sReq[k]   = 1'b1;
        sWrite[k] = wr;
        sAddr[k]  = a;
        sBe[k]    = be;
        sData[k]  = d;
        sLock[k]  = lk;
    endtask

    task automatic clearStage();
        sReq   = '0;
        sWrite = '0;
        sLock  = '0;
    endtask

    // Drive the staged values one step after the rising edge, then wait for
    // the falling edge where outputs are sampled.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        reset_n = sRst;
        mReq    = sReq;
        mWrite  = sWrite;
        mLock   = sLock;
        for (int k = 0; k < N; k++) begin
            mAddr[k] = sAddr[k];
            mBe[k]   = sBe[k];
            mData[k] = sData[k];
        end
        @(negedge clk);
    endtask

    int contOrder [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`ifdef ONCHIP_ARB_LOCK_EN
    int lockOrder [17] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
`else
    int lockOrder [17] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

    initial begin
        logic [N-1:0] w;
        logic [N-1:0] r;
        reset_n = 1'b0;
        sRst    = 1'b0;
        mReq = '0; mWrite = '0; mLock = '0;
        for (int k = 0; k < N; k++) begin
            mAddr[k] = '0; mBe[k] = '0; mData[k] = '0;
            sAddr[k] = '0; sBe[k] = '0; sData[k] = '0;
        end
        clearStage();

        // Reset held with every master requesting
        applyStimulus();
        for (int k = 0; k < N; k++) stage(k, 1'b0, AW'(k), 4'hF, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("rst_wait", 32'(bus.m_waitrequest), 32'hF);
            checkOutput("rst_cs", 32'(bus.mem_chipselect), 32'h0);
        end

        // Release, one idle cycle
        sRst = 1'b1;
        clearStage();
        applyStimulus();

        // Single master: write then read back
        stage(2, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
        applyStimulus();
        checkOutput("sm_wr_wait", 32'(bus.m_waitrequest), 32'hB);
        checkOutput("sm_wr_memwrite", 32'(bus.mem_write), 32'h1);
        stage(2, 1'b0, 13'h0010, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("sm_rd_wait", 32'(bus.m_waitrequest), 32'hB);
        checkOutput("sm_rd_memwrite", 32'(bus.mem_write), 32'h0);
        clearStage();
        applyStimulus();
        checkOutput("sm_rdv", 32'(bus.m_readdatavalid), 32'h4);
        checkOutput("sm_rdata", bus.m_readdata, 32'hDEADBEEF);

        // Preload a word per master for the contention and lock tests
        for (int k = 0; k < N; k++) begin
            clearStage();
            stage(k, 1'b1, 13'h0100 + AW'(k), 4'hF, 32'hC0DE0000 + 32'(k), 1'b0);
            applyStimulus();
        end

        // Byte-enabled write merge
        clearStage();
        stage(0, 1'b1, 13'd5, 4'hF, 32'h11223344, 1'b0);
        applyStimulus();
        stage(0, 1'b1, 13'd5, 4'b0010, 32'hAABBCCDD, 1'b0);
        applyStimulus();
        stage(0, 1'b0, 13'd5, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        clearStage();
        applyStimulus();
        checkOutput("bw_rdv", 32'(bus.m_readdatavalid), 32'h1);
        checkOutput("bw_rdata", bus.m_readdata, 32'h1122CC44);

        // Reset arriving right after an accepted read
        stage(3, 1'b0, 13'h0010, 4'hF, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("rr_accept_wait", 32'(bus.m_waitrequest), 32'h7);
        sRst = 1'b0;
        for (int k = 0; k < N; k++) stage(k, 1'b0, 13'h0100 + AW'(k), 4'hF, '0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus();
            checkOutput("rr_rdv", 32'(bus.m_readdatavalid), 32'h0);
            checkOutput("rr_wait", 32'(bus.m_waitrequest), 32'hF);
            checkOutput("rr_cs", 32'(bus.mem_chipselect), 32'h0);
        end

        // Contention straight out of reset: rotation must start at master 0
        sRst = 1'b1;
        for (int c = 0; c < 9; c++) begin
            applyStimulus();
            w = '1;
            w[contOrder[c]] = 1'b0;
            checkOutput("cont_wait", 32'(bus.m_waitrequest), 32'(w));
            if (c > 0) begin
                r = '0;
                r[contOrder[c-1]] = 1'b1;
                checkOutput("cont_rdv", 32'(bus.m_readdatavalid), 32'(r));
                checkOutput("cont_rdata", bus.m_readdata, 32'hC0DE0000 + 32'(contOrder[c-1]));
            end
        end

        // Lock scenario from a fresh reset: master 1 locks, master 0 joins
        sRst = 1'b0;
        clearStage();
        applyStimulus();
        sRst = 1'b1;
        stage(1, 1'b0, 13'h0101, 4'hF, '0, 1'b1);
        for (int c = 0; c < 17; c++) begin
            applyStimulus();
            w = '1;
            w[lockOrder[c]] = 1'b0;
            checkOutput("lock_wait", 32'(bus.m_waitrequest), 32'(w));
            if (c == 0) stage(0, 1'b0, 13'h0100, 4'hF, '0, 1'b0);
        end

        clearStage();
        applyStimulus();
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
